leb128_decoder: RTL and testbench

//   Decodes one LEB128 immediate (i32/i64 const, memarg, index) for the core's decode stage.

---
 rtl/leb128_decoder_pkg.sv | 20 ++
 rtl/leb128_decoder_step.sv | 55 +++++
 rtl/leb128_decoder.sv | 140 ++++++++++++++
 tb/tb_leb128_decoder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leb128_decoder_pkg.sv
// Shared encodings for the LEB128 immediate decoder: error codes and FSM states.
// The error encoding is also used by the core's trap mapping.
package leb128_decoder_pkg;

    typedef enum logic [1:0] {
        LEB_OK       = 2'd0,
        LEB_OVERLONG = 2'd1,
        LEB_BADBITS  = 2'd2,
        LEB_MEMERR   = 2'd3
    } leb_err_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_DECODE = 1'b1
    } leb_state_e;

    localparam logic [3:0] LEB_LAST_IDX_32 = 4'd4;
    localparam logic [3:0] LEB_LAST_IDX_64 = 4'd9;

endpackage

// File: rtl/leb128_decoder_step.sv
// One LEB128 byte step: accumulates the payload and, when the byte ends the
// encoding, produces the finished (extended or zeroed) value and error code.
module leb128_decoder_step
    import leb128_decoder_pkg::*;
(
    input  logic [63:0] acc_i,
    input  logic [6:0]  shift_i,
    input  logic [7:0]  byte_i,
    input  logic [3:0]  idx_i,
    input  logic        signed_i,
    input  logic        w64_i,
    output logic [63:0] acc_next_o,
    output logic [6:0]  shift_next_o,
    output logic        last_o,
    output leb_err_e    err_o,
    output logic [63:0] final_value_o
);

    logic        is_final;
    logic        bits_ok;
    logic [6:0]  width;
    logic [63:0] val;

    always_comb begin
        is_final     = (idx_i == (w64_i ? LEB_LAST_IDX_64 : LEB_LAST_IDX_32));
        width        = w64_i ? 7'd64 : 7'd32;
        acc_next_o   = acc_i | ({57'd0, byte_i[6:0]} << shift_i);
        shift_next_o = shift_i + 7'd7;
        last_o       = !byte_i[7] || is_final;

        // Payload bits of the final byte that lie beyond W must be pure zero/sign fill.
        if (w64_i)
            bits_ok = signed_i ? (byte_i[6:0] == 7'h00 || byte_i[6:0] == 7'h7F)
                               : (byte_i[6:1] == 6'd0);
        else
            bits_ok = signed_i ? (byte_i[6:4] == {3{byte_i[3]}})
                               : (byte_i[6:4] == 3'd0);

        err_o = LEB_OK;
        if (is_final && byte_i[7])
            err_o = LEB_OVERLONG;
        else if (is_final && !bits_ok)
            err_o = LEB_BADBITS;

        val = acc_next_o;
        if (signed_i && shift_next_o < width && byte_i[6])
            val = val | (~64'd0 << shift_next_o);
        if (!w64_i)
            val[63:32] = signed_i ? {32{val[31]}} : 32'd0;
        if (err_o != LEB_OK)
            val = 64'd0;
        final_value_o = val;
    end

endmodule

// File: rtl/leb128_decoder.sv
// LEB128 immediate decoder: latches a genrom byte window on start, then walks
// it one byte per cycle until the encoding terminates or overruns.
module leb128_decoder
    import leb128_decoder_pkg::*;
#(
    parameter bit          USE_64B   = 1'b1,
    parameter int unsigned MEM_EXTRA = 4     // window is 2**MEM_EXTRA bytes, >= 16 needed
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic                         signed_i,
    input  logic                         width64_i,
    input  logic [(2**MEM_EXTRA)*8-1:0]  mem_data_i,
    input  logic                         mem_error_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [63:0]                  value_o,
    output logic [3:0]                   length_o,
    output logic [1:0]                   error_o
);

    localparam int unsigned WIN_BYTES = 2**MEM_EXTRA;

    leb_state_e                       state_q, state_d;
    logic [WIN_BYTES-1:0][7:0]        win_q, win_d;
    logic                             signed_q, signed_d;
    logic                             w64_q, w64_d;
    logic [63:0]                      acc_q, acc_d;
    logic [6:0]                       shift_q, shift_d;
    logic [3:0]                       idx_q, idx_d;
    logic                             done_q, done_d;
    logic [63:0]                      value_q, value_d;
    logic [3:0]                       length_q, length_d;
    leb_err_e                         error_q, error_d;

    logic [MEM_EXTRA-1:0] byte_sel;
    logic [63:0]          acc_next;
    logic [6:0]           shift_next;
    logic                 last;
    leb_err_e             step_err;
    logic [63:0]          final_value;

    assign byte_sel = MEM_EXTRA'(idx_q);

    leb128_decoder_step u_step (
        .acc_i         (acc_q),
        .shift_i       (shift_q),
        .byte_i        (win_q[byte_sel]),
        .idx_i         (idx_q),
        .signed_i      (signed_q),
        .w64_i         (w64_q),
        .acc_next_o    (acc_next),
        .shift_next_o  (shift_next),
        .last_o        (last),
        .err_o         (step_err),
        .final_value_o (final_value)
    );

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        signed_d = signed_q;
        w64_d    = w64_q;
        acc_d    = acc_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        value_d  = value_q;
        length_d = length_q;
        error_d  = error_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                // A bad window never enters DECODE; the error is reported on the accepting edge.
                if (mem_error_i) begin
                    done_d   = 1'b1;
                    value_d  = 64'd0;
                    length_d = 4'd0;
                    error_d  = LEB_MEMERR;
                end else begin
                    state_d  = ST_DECODE;
                    win_d    = mem_data_i;
                    signed_d = signed_i;
                    w64_d    = width64_i & USE_64B;
                    acc_d    = 64'd0;
                    shift_d  = 7'd0;
                    idx_d    = 4'd0;
                end
            end
            ST_DECODE: begin
                acc_d   = acc_next;
                shift_d = shift_next;
                idx_d   = idx_q + 4'd1;
                if (last) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    value_d  = final_value;
                    length_d = idx_q + 4'd1;
                    error_d  = step_err;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            signed_q <= 1'b0;
            w64_q    <= 1'b0;
            acc_q    <= 64'd0;
            shift_q  <= 7'd0;
            idx_q    <= 4'd0;
            done_q   <= 1'b0;
            value_q  <= 64'd0;
            length_q <= 4'd0;
            error_q  <= LEB_OK;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            signed_q <= signed_d;
            w64_q    <= w64_d;
            acc_q    <= acc_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            value_q  <= value_d;
            length_q <= length_d;
            error_q  <= error_d;
        end
    end

    assign busy_o   = (state_q == ST_DECODE);
    assign done_o   = done_q;
    assign value_o  = value_q;
    assign length_o = length_q;
    assign error_o  = error_q;

endmodule

// File: tb/tb_leb128_decoder.sv
// Scoreboard bench: two decoders (64-bit enabled / 32-bit only) share one stimulus
// stream; expectations come from an arithmetic LEB128 model.
`timescale 1ns/100ps
module tb_leb128_decoder;

    typedef struct {
        logic [63:0] value;
        logic [3:0]  length;
        logic [1:0]  err;
        int          lat;
        int          cyc;
    } exp_t;

    logic         clk = 1'b0, rst_n = 1'b1;
    logic         start = 1'b0, sgn = 1'b0, w64 = 1'b0, merr = 1'b0;
    logic [127:0] win = '0;
    logic         busy0, done0, busy1, done1;
    logic [63:0]  val0, val1;
    logic [3:0]   len0, len1;
    logic [1:0]   err0, err1;

    int   cyc = 0;
    int   vectors = 0, miscompares = 0;
    bit   mon_en = 1'b0;
    exp_t q0[$], q1[$];
    exp_t held0, held1;
    int   blo0 = 1, bhi0 = 0, blo1 = 1, bhi1 = 0;

    leb128_decoder #(.USE_64B(1'b1), .MEM_EXTRA(4)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .signed_i(sgn), .width64_i(w64),
        .mem_data_i(win), .mem_error_i(merr), .busy_o(busy0), .done_o(done0),
        .value_o(val0), .length_o(len0), .error_o(err0));

    leb128_decoder #(.USE_64B(1'b0), .MEM_EXTRA(4)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .signed_i(sgn), .width64_i(w64),
        .mem_data_i(win), .mem_error_i(merr), .busy_o(busy1), .done_o(done1),
        .value_o(val1), .length_o(len1), .error_o(err1));

    always #1 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Value of a LEB128 encoding computed as a bit string of 7-bit groups.
    function automatic exp_t model(input logic [127:0] w, input bit sg, input bit wd, input bit me);
        exp_t r;
        int mx, wb, n, hb;
        logic [69:0] p, hi, ones;
        logic [127:0] t;
        logic [7:0] b;
        r = '{64'd0, 4'd0, 2'd0, 0, 0};
        if (me) begin
            r.err = 2'd3;
            return r;
        end
        mx = wd ? 10 : 5;
        wb = wd ? 64 : 32;
        p  = '0;
        n  = 0;
        for (int k = 0; k < mx; k++) begin
            b = w[8*k +: 8];
            p = p | (70'(b[6:0]) << (7*k));
            if (!b[7]) begin
                n = k + 1;
                break;
            end
        end
        r.length = 4'(mx);
        r.lat    = mx;
        if (n == 0) begin
            r.err = 2'd1;
            return r;
        end
        if (n == mx) begin
            hb   = 7*mx - wb + 1;
            ones = (70'd1 << hb) - 70'd1;
            hi   = p >> (wb - 1);
            if (sg ? !(hi == 70'd0 || hi == ones) : ((p >> wb) != 70'd0)) begin
                r.err = 2'd2;
                return r;
            end
        end
        r.length = 4'(n);
        r.lat    = n;
        t = 128'(p);
        if (sg && p[7*n-1]) t = t | (~128'd0 << (7*n));
        if (!wd) t = sg ? {{96{t[31]}}, t[31:0]} : {96'd0, t[31:0]};
        r.value = t[63:0];
        return r;
    endfunction

    task automatic mon(input int i, input logic busy, input logic done,
                       input logic [63:0] v, input logic [3:0] l, input logic [1:0] e);
        exp_t x;
        int lo, hi, qs;
        lo = (i == 0) ? blo0 : blo1;
        hi = (i == 0) ? bhi0 : bhi1;
        qs = (i == 0) ? q0.size() : q1.size();
        chk($sformatf("busy%0d", i), 64'(busy), 64'(cyc >= lo && cyc <= hi));
        if (done) begin
            if (qs == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL done%0d: unexpected done pulse (cycle %0d)", i, cyc);
            end else begin
                x = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("done_cycle%0d", i), 64'(cyc), 64'(x.cyc));
                chk($sformatf("value%0d", i), v, x.value);
                chk($sformatf("length%0d", i), 64'(l), 64'(x.length));
                chk($sformatf("error%0d", i), 64'(e), 64'(x.err));
                if (i == 0) held0 = x; else held1 = x;
            end
        end else begin
            if (qs != 0) begin
                x = (i == 0) ? q0[0] : q1[0];
                if (x.cyc < cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL missing_done%0d: got none expected cycle %0d (cycle %0d)", i, x.cyc, cyc);
                    if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
            x = (i == 0) ? held0 : held1;
            chk($sformatf("held_value%0d", i), v, x.value);
            chk($sformatf("held_length%0d", i), 64'(l), 64'(x.length));
            chk($sformatf("held_error%0d", i), 64'(e), 64'(x.err));
        end
    endtask

    always @(negedge clk) if (mon_en) begin
        mon(0, busy0, done0, val0, len0, err0);
        mon(1, busy1, done1, val1, len1, err1);
    end

    task automatic tick();
        @(posedge clk);
        #0.2;
    endtask

    // Issue a start in the current cycle and return in the cycle where the later decoder
    // shows done, so the next issue lands back-to-back in that done cycle.
    task automatic issue(input logic [127:0] w, input bit s, input bit wd, input bit me, input bit junk);
        exp_t e0, e1;
        int k, n, maxd;
        k = cyc;
        start = 1'b1; win = w; sgn = s; w64 = wd; merr = me;
        e0 = model(w, s, wd, me);
        e1 = model(w, s, 1'b0, me);
        e0.cyc = k + 1 + e0.lat;
        e1.cyc = k + 1 + e1.lat;
        q0.push_back(e0);
        q1.push_back(e1);
        blo0 = k + 1; bhi0 = k + e0.lat;
        blo1 = k + 1; bhi1 = k + e1.lat;
        n    = (e0.lat < e1.lat) ? e0.lat : e1.lat;
        maxd = (e0.cyc > e1.cyc) ? e0.cyc : e1.cyc;
        tick();
        start = 1'b0;
        while (cyc < maxd) begin
            if (junk && cyc <= k + n && $urandom_range(0, 2) == 0) begin
                start = 1'b1;
                win   = {$urandom, $urandom, $urandom, $urandom};
                sgn   = 1'($urandom);
                w64   = 1'($urandom);
                merr  = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        merr  = 1'b0;
    endtask

    task automatic directed(input string name, input logic [127:0] w, input bit s, input bit wd,
                            input bit me, input bit junk,
                            input logic [63:0] ev, input logic [3:0] el, input logic [1:0] ee);
        issue(w, s, wd, me, junk);
        chk({name, "_value"}, val0, ev);
        chk({name, "_length"}, 64'(len0), 64'(el));
        chk({name, "_error"}, 64'(err0), 64'(ee));
    endtask

    initial begin
        logic [127:0] w;
        bit s, wd, me;
        int n, mx, lastb;

        #0.1 rst_n = 1'b0;
        #0.3;
        chk("reset_busy", 64'(busy0), 64'd0);
        chk("reset_done", 64'(done0), 64'd0);
        chk("reset_value", val0, 64'd0);
        chk("reset_length", 64'(len0), 64'd0);
        chk("reset_error", 64'(err0), 64'd0);
        held0 = '{64'd0, 4'd0, 2'd0, 0, 0};
        held1 = held0;
        tick();
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        directed("uleb32_3b", 128'h26_8E_E5, 0, 0, 0, 0, 64'h0000_0000_0009_8765, 4'd3, 2'd0);
        directed("sleb32_neg", 128'h78_BB_C0, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 2'd0);
        directed("sleb64_7f", 128'h7F, 1, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 2'd0);
        directed("uleb32_max", 128'h0F_FF_FF_FF_FF, 0, 0, 0, 0, 64'h0000_0000_FFFF_FFFF, 4'd5, 2'd0);
        directed("uleb32_bad", 128'h1F_FF_FF_FF_FF, 0, 0, 0, 0, 64'd0, 4'd5, 2'd2);
        directed("uleb32_over", 128'hFF_FF_FF_FF_FF, 0, 0, 0, 0, 64'd0, 4'd5, 2'd1);
        directed("uleb64_10b", 128'h01_80_80_80_80_80_80_80_80_80, 0, 1, 0, 0,
                 64'h8000_0000_0000_0000, 4'd10, 2'd0);
        chk("no64_over_length", 64'(len1), 64'd5);
        chk("no64_over_error", 64'(err1), 64'd1);
        directed("memerr", 128'h05, 0, 0, 1, 0, 64'd0, 4'd0, 2'd3);
        directed("busy_start", 128'h26_8E_E5, 0, 0, 0, 1, 64'h0000_0000_0009_8765, 4'd3, 2'd0);

        // Abort a 10-byte decode with reset; everything must clear at once.
        mon_en = 1'b0;
        start = 1'b1; win = 128'h01_80_80_80_80_80_80_80_80_80; sgn = 1'b0; w64 = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre_reset_busy", 64'(busy0), 64'd1);
        rst_n = 1'b0;
        #0.1;
        chk("midreset_busy", 64'(busy0), 64'd0);
        chk("midreset_done", 64'(done0), 64'd0);
        chk("midreset_value", val0, 64'd0);
        chk("midreset_length", 64'(len0), 64'd0);
        chk("midreset_error", 64'(err0), 64'd0);
        q0.delete();
        q1.delete();
        held0 = '{64'd0, 4'd0, 2'd0, 0, 0};
        held1 = held0;
        blo0 = 1; bhi0 = 0; blo1 = 1; bhi1 = 0;
        tick();
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        directed("after_reset", 128'h05, 0, 0, 0, 0, 64'd5, 4'd1, 2'd0);

        for (int t = 0; t < 400; t++) begin
            s  = 1'($urandom);
            wd = 1'($urandom);
            me = ($urandom_range(0, 19) == 0);
            n  = $urandom_range(1, 11);
            mx = wd ? 10 : 5;
            w  = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < 16; k++) begin
                if (k < n - 1) w[8*k+7] = 1'b1;
                else if (k == n - 1) w[8*k+7] = 1'b0;
            end
            // Half of the full-length encodings get a legal final byte.
            if (n == mx && $urandom_range(0, 1) == 1) begin
                lastb = 8 * (mx - 1);
                if (wd) w[lastb +: 7] = s ? ($urandom_range(0, 1) ? 7'h7F : 7'h00) : 7'($urandom_range(0, 1));
                else if (s) w[lastb +: 7] = $urandom_range(0, 1) ? {4'hF, 3'($urandom)} : {4'h0, 3'($urandom)};
                else w[lastb +: 7] = 7'($urandom_range(0, 15));
            end
            issue(w, s, wd, me, 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        chk("queue0_drained", 64'(q0.size()), 64'd0);
        chk("queue1_drained", 64'(q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
